excp_ctrl: RTL and testbench

Trap/return sequencer for the in-order pipeline, driving the exception-side ports of the CSR file and consuming its mtvec and mepc read ports. It samples a committing instruction's exception or mret in WB, writes mcause, mepc and mtval, flushes the pipeline and issues a PC redirect to the trap vector or the saved return address. A small state machine serialises each trap, and the controller holds the pipeline while a sequence is in flight.

---
 rtl/excp_ctrl.sv | 137 +++++++++++++
 tb/tb_excp_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_ctrl.sv
// -----------------------------------------------------------------------------
// excp_ctrl -- trap / mret sequencer for the in-order pipeline.
//
// Samples a committing WB instruction that raised an exception or is an mret.
// An exception runs TRAP (mcause/mepc/mtval writes, flush+stall) and then
// REDIR (redirect to mtvec, flush+stall). An mret runs MRET (redirect to
// mepc, flush only). WB inputs are only looked at while IDLE.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wb_valid_i                instruction committing in WB
//   wb_pc_i                   PC of the WB instruction
//   wb_excp_i                 WB instruction raised an exception
//   wb_excp_code_i            exception code (0..15)
//   wb_excp_tval_i            trap value
//   wb_mret_i                 WB instruction is mret
//   mtvec_rdata_i             current mtvec from the CSR file
//   mepc_rdata_i              current mepc from the CSR file
//   mcause_wen_o/_wdata_o     mcause write port
//   mepc_wen_o/_wdata_o       mepc write port
//   mtval_wen_o/_wdata_o      mtval write port
//   flush_o                   kill IF..WB, block CSR writes from WB
//   stall_o                   freeze PC and pipeline registers
//   redirect_valid_o          load redirect_pc_o into the fetch PC
//   redirect_pc_o             redirect target
//
// Handshake: there is no back-pressure. An event is accepted on the clock
// edge where the controller is IDLE and wb_valid_i is high; every other
// sampled WB event is dropped because the pipeline is being flushed.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module excp_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid_i,
  input  logic [`XLEN-1:0]  wb_pc_i,
  input  logic              wb_excp_i,
  input  logic [3:0]        wb_excp_code_i,
  input  logic [`XLEN-1:0]  wb_excp_tval_i,
  input  logic              wb_mret_i,
  input  logic [`XLEN-1:0]  mtvec_rdata_i,
  input  logic [`XLEN-1:0]  mepc_rdata_i,
  output logic              mcause_wen_o,
  output logic [`XLEN-1:0]  mcause_wdata_o,
  output logic              mepc_wen_o,
  output logic [`XLEN-1:0]  mepc_wdata_o,
  output logic              mtval_wen_o,
  output logic [`XLEN-1:0]  mtval_wdata_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              redirect_valid_o,
  output logic [`XLEN-1:0]  redirect_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_REDIR = 2'd2,
    S_MRET  = 2'd3
  } state_e;

  // Clears the two low bits: targets and mepc are always word aligned.
  localparam logic [`XLEN-1:0] ALIGN_MASK = {{(`XLEN-2){1'b1}}, 2'b00};

  state_e            state_q, state_d;
  logic [`XLEN-1:0]  pc_q;
  logic [`XLEN-1:0]  tval_q;
  logic [3:0]        code_q;
  // One-hot registered phase flags; all outputs decode from these only.
  logic              trap_q, redir_q, mret_q;

  logic              take_excp, take_mret;

  // Exception has priority over mret; both need a valid commit in IDLE.
  assign take_excp = (state_q == S_IDLE) && wb_valid_i && wb_excp_i;
  assign take_mret = (state_q == S_IDLE) && wb_valid_i && !wb_excp_i && wb_mret_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_excp)      state_d = S_TRAP;
        else if (take_mret) state_d = S_MRET;
      end
      S_TRAP:  state_d = S_REDIR;
      S_REDIR: state_d = S_IDLE;
      S_MRET:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      tval_q  <= '0;
      code_q  <= '0;
      trap_q  <= 1'b0;
      redir_q <= 1'b0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == S_TRAP);
      redir_q <= (state_d == S_REDIR);
      mret_q  <= (state_d == S_MRET);
      if (take_excp) begin
        pc_q   <= wb_pc_i;
        tval_q <= wb_excp_tval_i;
        code_q <= wb_excp_code_i;
      end
    end
  end

  // CSR write port: only live during TRAP, zero otherwise.
  assign mcause_wen_o   = trap_q;
  assign mepc_wen_o     = trap_q;
  assign mtval_wen_o    = trap_q;
  assign mcause_wdata_o = trap_q ? {{(`XLEN-4){1'b0}}, code_q} : '0;
  assign mepc_wdata_o   = trap_q ? (pc_q & ALIGN_MASK) : '0;
  assign mtval_wdata_o  = trap_q ? tval_q : '0;

  assign flush_o          = trap_q | redir_q | mret_q;
  assign stall_o          = trap_q | redir_q;
  assign redirect_valid_o = redir_q | mret_q;

  // The CSR read data is taken live so that the mtvec/mepc value written at
  // the previous edge (including the TRAP writes) is the one used.
  always_comb begin
    redirect_pc_o = '0;
    if (redir_q)     redirect_pc_o = mtvec_rdata_i & ALIGN_MASK;
    else if (mret_q) redirect_pc_o = mepc_rdata_i & ALIGN_MASK;
  end

endmodule

// File: tb/tb_excp_ctrl.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_excp_ctrl;

  localparam int W = `XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wb_valid_i = 1'b0;
  logic [W-1:0]  wb_pc_i = '0;
  logic          wb_excp_i = 1'b0;
  logic [3:0]    wb_excp_code_i = '0;
  logic [W-1:0]  wb_excp_tval_i = '0;
  logic          wb_mret_i = 1'b0;
  logic [W-1:0]  mtvec_rdata_i = '0;
  logic [W-1:0]  mepc_rdata_i = '0;
  logic          mcause_wen_o, mepc_wen_o, mtval_wen_o;
  logic [W-1:0]  mcause_wdata_o, mepc_wdata_o, mtval_wdata_o;
  logic          flush_o, stall_o, redirect_valid_o;
  logic [W-1:0]  redirect_pc_o;

  excp_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid_i       (wb_valid_i),
    .wb_pc_i          (wb_pc_i),
    .wb_excp_i        (wb_excp_i),
    .wb_excp_code_i   (wb_excp_code_i),
    .wb_excp_tval_i   (wb_excp_tval_i),
    .wb_mret_i        (wb_mret_i),
    .mtvec_rdata_i    (mtvec_rdata_i),
    .mepc_rdata_i     (mepc_rdata_i),
    .mcause_wen_o     (mcause_wen_o),
    .mcause_wdata_o   (mcause_wdata_o),
    .mepc_wen_o       (mepc_wen_o),
    .mepc_wdata_o     (mepc_wdata_o),
    .mtval_wen_o      (mtval_wen_o),
    .mtval_wdata_o    (mtval_wdata_o),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  // ---------------- reference model ----------------
  // One record per future cycle of the sequence in flight. An empty queue
  // means the controller is idle and may accept a new event.
  typedef struct {
    logic         wen;
    logic [W-1:0] mcause;
    logic [W-1:0] mepc;
    logic [W-1:0] mtval;
    logic         flush;
    logic         stall;
    logic         rv;
    int           src;   // 0: no redirect, 1: mtvec, 2: mepc
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   mepc_writes = 0;

  function automatic exp_t idle_rec();
    exp_t r;
    r.wen = 1'b0; r.mcause = '0; r.mepc = '0; r.mtval = '0;
    r.flush = 1'b0; r.stall = 1'b0; r.rv = 1'b0; r.src = 0;
    return r;
  endfunction

  // Applied at each rising edge with the inputs the DUT samples there.
  task automatic model_edge();
    exp_t r;
    bit idle;
    idle = (exp_q.size() == 0);
    if (!idle) void'(exp_q.pop_front());
    if (idle && wb_valid_i) begin
      if (wb_excp_i) begin
        r = idle_rec();
        r.wen    = 1'b1;
        r.mcause = W'(wb_excp_code_i);
        r.mepc   = wb_pc_i - (wb_pc_i % 4);
        r.mtval  = wb_excp_tval_i;
        r.flush  = 1'b1;
        r.stall  = 1'b1;
        exp_q.push_back(r);
        r = idle_rec();
        r.rv = 1'b1; r.src = 1; r.flush = 1'b1; r.stall = 1'b1;
        exp_q.push_back(r);
      end else if (wb_mret_i) begin
        r = idle_rec();
        r.rv = 1'b1; r.src = 2; r.flush = 1'b1;
        exp_q.push_back(r);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    exp_t e;
    logic [W-1:0] tgt;
    e = idle_rec();
    if (exp_q.size() > 0) e = exp_q[0];
    tgt = '0;
    if (e.src == 1) tgt = mtvec_rdata_i - (mtvec_rdata_i % 4);
    if (e.src == 2) tgt = mepc_rdata_i - (mepc_rdata_i % 4);
    if (mepc_wen_o === 1'b1) mepc_writes++;
    chk("mcause_wen",   W'(mcause_wen_o),     W'(e.wen));
    chk("mepc_wen",     W'(mepc_wen_o),       W'(e.wen));
    chk("mtval_wen",    W'(mtval_wen_o),      W'(e.wen));
    chk("mcause_wdata", mcause_wdata_o,       e.mcause);
    chk("mepc_wdata",   mepc_wdata_o,         e.mepc);
    chk("mtval_wdata",  mtval_wdata_o,        e.mtval);
    chk("flush",        W'(flush_o),          W'(e.flush));
    chk("stall",        W'(stall_o),          W'(e.stall));
    chk("redir_valid",  W'(redirect_valid_o), W'(e.rv));
    chk("redir_pc",     redirect_pc_o,        tgt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wb_clear();
    wb_valid_i = 1'b0; wb_excp_i = 1'b0; wb_mret_i = 1'b0;
    wb_pc_i = '0; wb_excp_code_i = '0; wb_excp_tval_i = '0;
  endtask

  task automatic wb_excp(input logic [W-1:0] pc, input logic [3:0] code, input logic [W-1:0] tval);
    wb_valid_i = 1'b1; wb_excp_i = 1'b1; wb_mret_i = 1'b0;
    wb_pc_i = pc; wb_excp_code_i = code; wb_excp_tval_i = tval;
  endtask

  task automatic wb_mret();
    wb_valid_i = 1'b1; wb_excp_i = 1'b0; wb_mret_i = 1'b1;
    wb_pc_i = '0; wb_excp_code_i = '0; wb_excp_tval_i = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset state
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    step();

    // Basic trap
    mtvec_rdata_i = 32'h8000_0100;
    wb_excp(32'h0000_0204, 4'd2, 32'h0000_0013);
    step();
    chk("basic_mcause", mcause_wdata_o, 32'h2);
    chk("basic_mepc",   mepc_wdata_o,   32'h204);
    chk("basic_mtval",  mtval_wdata_o,  32'h13);
    wb_clear();
    step();
    chk("basic_redir", redirect_pc_o, 32'h8000_0100);
    step();

    // mret
    mepc_rdata_i = 32'h0000_0208;
    wb_mret();
    step();
    chk("mret_pc",    redirect_pc_o, 32'h208);
    chk("mret_stall", W'(stall_o),   '0);
    wb_clear();
    step();

    // Priority: exception beats mret
    mepc_rdata_i = 32'h0000_0300;
    wb_excp(32'h0000_0400, 4'd11, 32'h0);
    wb_mret_i = 1'b1;
    step();
    chk("prio_mcause", mcause_wdata_o, 32'hb);
    wb_clear();
    step();
    chk("prio_redir", redirect_pc_o, 32'h8000_0100);
    step();

    // Invalid commit ignored
    wb_excp(32'h0000_0500, 4'd5, 32'h55);
    wb_valid_i = 1'b0;
    step();
    chk("novalid_wen", W'(mcause_wen_o), '0);
    wb_clear();

    // Second exception during TRAP/REDIR ignored
    mepc_writes = 0;
    wb_excp(32'h0000_0600, 4'd4, 32'h66);
    step();
    wb_excp(32'h0000_0700, 4'd7, 32'h77);
    step();
    wb_clear();
    step();
    step();
    chk("single_mepc_write", W'(mepc_writes), W'(1));

    // Alignment
    mtvec_rdata_i = 32'h8000_0103;
    wb_excp(32'h0000_0206, 4'd0, 32'h0);
    step();
    chk("align_mepc", mepc_wdata_o, 32'h204);
    wb_clear();
    step();
    chk("align_redir", redirect_pc_o, 32'h8000_0100);
    step();

    // Reset in the middle of TRAP
    wb_excp(32'h0000_0800, 4'd3, 32'h88);
    step();
    wb_clear();
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_wen",   W'(mcause_wen_o), '0);
    chk("rst_flush", W'(flush_o),      '0);
    chk("rst_stall", W'(stall_o),      '0);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    step();
    chk("rst_no_redir", W'(redirect_valid_o), '0);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      wb_valid_i     = ($urandom_range(0, 1) == 1);
      wb_excp_i      = ($urandom_range(0, 3) == 0);
      wb_mret_i      = ($urandom_range(0, 3) == 0);
      wb_excp_code_i = 4'($urandom_range(0, 15));
      wb_pc_i        = $urandom;
      wb_excp_tval_i = $urandom;
      if ($urandom_range(0, 3) == 0) mtvec_rdata_i = $urandom;
      if ($urandom_range(0, 3) == 0) mepc_rdata_i  = $urandom;
      step();
    end
    wb_clear();
    step();
    step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
